// File: rtl/monitor_prg_access.sv
// Program-memory access bridge between a debug monitor's MA/MD/command ports
// and the halted target's program memory, using a four-phase ack handshake.
module monitor_prg_access #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ma,
    input  logic [7:0] md,
    input  logic [1:0] cmd,
    input  logic       target_halt,
    input  logic [7:0] prg_rdata,
    output logic [7:0] prg_addr,
    output logic [7:0] prg_wdata,
    output logic       prg_we,
    output logic       prg_re,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b10;
    localparam logic [1:0] CMD_BAD = 2'b11;
    localparam logic [3:0] LAT     = 4'(RD_LAT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] rd_cnt;
    logic       accept;
    logic       reject;

    // Halt is sampled only here, so a halt drop mid-access cannot abort it.
    assign accept = (state == IDLE) && (cmd != 2'b00);
    assign reject = (cmd == CMD_BAD) || !target_halt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment before the case keeps this purely
    // combinational; a missing path would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd != 2'b00) begin
                    if (reject)             state_nxt = ACK;
                    else if (cmd == CMD_WR) state_nxt = WR;
                    else                    state_nxt = RD;
                end
            end
            WR:      state_nxt = ACK;
            RD:      if (rd_cnt == 4'd1) state_nxt = ACK;
            ACK:     if (cmd == 2'b00) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        prg_we = 1'b0;
        prg_re = 1'b0;
        ack    = 1'b0;
        busy   = 1'b1;
        unique case (state)
            IDLE:    busy   = 1'b0;
            WR:      prg_we = 1'b1;
            RD:      prg_re = 1'b1;
            ACK:     ack    = 1'b1;
            default: busy   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prg_addr  <= 8'h00;
            prg_wdata <= 8'h00;
            rdata     <= 8'h00;
            err       <= 1'b0;
            rd_cnt    <= 4'd0;
        end else begin
            if (accept) begin
                prg_addr  <= ma;
                prg_wdata <= md;
                err       <= reject;
                if (!reject && (cmd == CMD_RD)) begin
                    rd_cnt <= LAT;
                end
            end
            if (state == RD) begin
                rd_cnt <= rd_cnt - 4'd1;
                if (rd_cnt == 4'd1) begin
                    rdata <= prg_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_monitor_prg_access.sv
// Scoreboard bench: one instance at RD_LAT=2 for the handshake scenarios and
// one at RD_LAT=4 for long reads and the reset-during-read case.
module tb_monitor_prg_access;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] ma, md;
    logic [1:0] cmd, cmd4;
    logic       target_halt;

    logic [7:0] prg_rdata, prg_addr, prg_wdata, rdata;
    logic       prg_we, prg_re, ack, err, busy;
    logic [7:0] prg_rdata4, prg_addr4, prg_wdata4, rdata4;
    logic       prg_we4, prg_re4, ack4, err4, busy4;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        int         n_we;
        int         n_re;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];

    // Target memory: unwritten locations return a fixed address pattern.
    bit [7:0] mem[256];
    bit       mem_vld[256];
    bit [7:0] model_mem[256];
    bit       model_vld[256];
    logic [7:0] model_rdata;

    always #5 clk = ~clk;

    monitor_prg_access #(.RD_LAT(2)) dut (
        .clk(clk), .reset_n(reset_n), .ma(ma), .md(md), .cmd(cmd),
        .target_halt(target_halt), .prg_rdata(prg_rdata),
        .prg_addr(prg_addr), .prg_wdata(prg_wdata), .prg_we(prg_we),
        .prg_re(prg_re), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    monitor_prg_access #(.RD_LAT(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .ma(ma), .md(md), .cmd(cmd4),
        .target_halt(target_halt), .prg_rdata(prg_rdata4),
        .prg_addr(prg_addr4), .prg_wdata(prg_wdata4), .prg_we(prg_we4),
        .prg_re(prg_re4), .rdata(rdata4), .ack(ack4), .err(err4), .busy(busy4)
    );

    function automatic logic [7:0] pat(input logic [7:0] a);
        return a ^ 8'h4A;
    endfunction

    function automatic logic [7:0] exp_mem(input logic [7:0] a);
        return model_vld[a] ? model_mem[a] : pat(a);
    endfunction

    assign prg_rdata  = mem_vld[prg_addr]  ? mem[prg_addr]  : pat(prg_addr);
    assign prg_rdata4 = mem_vld[prg_addr4] ? mem[prg_addr4] : pat(prg_addr4);

    always @(posedge clk) begin
        if (prg_we) begin
            mem[prg_addr]     <= prg_wdata;
            mem_vld[prg_addr] <= 1'b1;
        end
    end

    // One full command on the RD_LAT=2 instance. chg perturbs ma/md/halt
    // right after acceptance; hold keeps cmd asserted in ACK for extra cycles.
    task automatic do_cmd(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d,
                          input logic h, input bit chg, input int hold, input string nm);
        exp_t e;
        int   cyc, n_we, n_re;
        bit   got;
        e.addr  = a;
        e.wdata = d;
        e.err   = (c == 2'b11) || !h;
        e.n_we  = (!e.err && c == 2'b01) ? 1 : 0;
        e.n_re  = (!e.err && c == 2'b10) ? 2 : 0;
        if (e.n_we != 0) begin
            model_mem[a] = d;
            model_vld[a] = 1'b1;
        end
        if (e.n_re != 0) model_rdata = exp_mem(a);
        e.rdata = model_rdata;
        sb.push_back(e);

        @(negedge clk);
        ma = a; md = d; cmd = c; target_halt = h;
        cyc = 0; n_we = 0; n_re = 0; got = 1'b0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc++;
            if (prg_we) begin
                n_we++;
                checks++;
                if (prg_addr !== a || prg_wdata !== d) begin
                    failures++;
                    $display("FAIL %s wr_bus: addr=%h wdata=%h expected addr=%h wdata=%h",
                             nm, prg_addr, prg_wdata, a, d);
                end
            end
            if (prg_re) n_re++;
            if (prg_we && prg_re) begin
                checks++;
                failures++;
                $display("FAIL %s we_re_overlap: both strobes high, expected exclusive", nm);
            end
            if (ack) got = 1'b1;
            if (chg && cyc == 1) begin
                ma = 8'h77; md = ~d; target_halt = 1'b0;
            end
        end
        e = sb.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s ack_timeout: no ack within %0d cycles", nm, cyc);
        end else if (cyc !== e.n_we + e.n_re + 1) begin
            failures++;
            $display("FAIL %s latency: ack after %0d cycles, expected %0d", nm, cyc, e.n_we + e.n_re + 1);
        end
        checks++;
        if (n_we !== e.n_we || n_re !== e.n_re) begin
            failures++;
            $display("FAIL %s strobes: we=%0d re=%0d expected we=%0d re=%0d", nm, n_we, n_re, e.n_we, e.n_re);
        end
        checks++;
        if (err !== e.err || rdata !== e.rdata || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s ack_state: err=%b rdata=%h busy=%b expected err=%b rdata=%h busy=1",
                     nm, err, rdata, busy, e.err, e.rdata);
        end
        checks++;
        if (prg_addr !== e.addr || prg_wdata !== e.wdata) begin
            failures++;
            $display("FAIL %s latched: addr=%h wdata=%h expected addr=%h wdata=%h",
                     nm, prg_addr, prg_wdata, e.addr, e.wdata);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b1 || prg_we !== 1'b0 || prg_re !== 1'b0) begin
                failures++;
                $display("FAIL %s hold: ack=%b we=%b re=%b expected ack=1 we=0 re=0", nm, ack, prg_we, prg_re);
            end
        end
        cmd = 2'b00;
        target_halt = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s release: ack=%b busy=%b expected 0 0", nm, ack, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ma = 8'h00; md = 8'h00; cmd = 2'b00; cmd4 = 2'b00;
        target_halt = 1'b0; model_rdata = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({prg_addr, prg_wdata, prg_we, prg_re, rdata, ack, err, busy} !== 30'd0 ||
            {prg_addr4, prg_wdata4, prg_we4, prg_re4, rdata4, ack4, err4, busy4} !== 30'd0) begin
            failures++;
            $display("FAIL reset_values: dut=%h dut4=%h expected all zero",
                     {prg_addr, prg_wdata, prg_we, prg_re, rdata, ack, err, busy},
                     {prg_addr4, prg_wdata4, prg_we4, prg_re4, rdata4, ack4, err4, busy4});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b busy4=%b expected 0 0", busy, busy4);
        end
    endtask

    task automatic test_write();
        do_cmd(2'b01, 8'h3C, 8'hA5, 1'b1, 1'b1, 0, "write_3c");
    endtask

    task automatic test_read();
        do_cmd(2'b10, 8'h10, 8'h00, 1'b1, 1'b0, 0, "read_10");
        do_cmd(2'b10, 8'h3C, 8'h00, 1'b1, 1'b1, 0, "read_back_3c");
    endtask

    task automatic test_reject();
        do_cmd(2'b01, 8'h44, 8'h99, 1'b0, 1'b0, 0, "reject_nohalt");
        do_cmd(2'b10, 8'h44, 8'h00, 1'b1, 1'b0, 0, "read_clears_err");
    endtask

    task automatic test_illegal();
        do_cmd(2'b11, 8'h55, 8'h66, 1'b1, 1'b0, 10, "illegal_cmd");
    endtask

    task automatic test_idle_hold();
        repeat (4) @(negedge clk);
        checks++;
        if (prg_addr !== 8'h55 || prg_wdata !== 8'h66 || busy !== 1'b0 || prg_we !== 1'b0 || prg_re !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: addr=%h wdata=%h busy=%b we=%b re=%b expected 55 66 0 0 0",
                     prg_addr, prg_wdata, busy, prg_we, prg_re);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, d;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            do_cmd(2'b01, a, d, 1'b1, 1'b0, 0, "b2b_write");
            do_cmd(2'b10, a, 8'h00, 1'b1, 1'b0, 0, "b2b_read");
        end
    endtask

    task automatic test_read_lat4();
        int  cyc, n_re;
        bit  got;
        @(negedge clk);
        ma = 8'h21; cmd4 = 2'b10; target_halt = 1'b1;
        cyc = 0; n_re = 0; got = 1'b0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc++;
            if (prg_re4) n_re++;
            if (ack4) got = 1'b1;
        end
        checks++;
        if (!got || n_re !== 4 || cyc !== 5) begin
            failures++;
            $display("FAIL read_lat4: got_ack=%b re_cycles=%0d ack_cycle=%0d expected 1 4 5", got, n_re, cyc);
        end
        checks++;
        if (rdata4 !== exp_mem(8'h21) || err4 !== 1'b0) begin
            failures++;
            $display("FAIL read_lat4_data: rdata=%h err=%b expected %h 0", rdata4, err4, exp_mem(8'h21));
        end
        cmd4 = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        ma = 8'h30; cmd4 = 2'b10; target_halt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (prg_re4 !== 1'b1) begin
            failures++;
            $display("FAIL mid_read_active: re=%b expected 1 in second read cycle", prg_re4);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({prg_addr4, prg_wdata4, prg_we4, prg_re4, rdata4, ack4, err4, busy4} !== 30'd0 ||
            {prg_addr, rdata, busy} !== 17'd0) begin
            failures++;
            $display("FAIL mid_read_reset: dut4=%h dut=%h expected all zero",
                     {prg_addr4, prg_wdata4, prg_we4, prg_re4, rdata4, ack4, err4, busy4},
                     {prg_addr, rdata, busy});
        end
        model_rdata = 8'h00;
        cmd4 = 2'b00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy4 !== 1'b0 || prg_re4 !== 1'b0 || rdata4 !== 8'h00) begin
                failures++;
                $display("FAIL post_reset_idle: busy=%b re=%b rdata=%h expected 0 0 00", busy4, prg_re4, rdata4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_reject();
        test_illegal();
        test_idle_hold();
        test_back_to_back();
        test_read_lat4();
        test_reset_mid_read();
        do_cmd(2'b10, 8'h10, 8'h00, 1'b1, 1'b0, 0, "read_after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
